// File: rtl/spike_channel_scheduler_pkg.sv
// Shared types, width constants and helpers for the spike channel scheduler.
// Default parameter values live here so the interface and RTL agree on them.
package spike_channel_scheduler_pkg;

    localparam int DEF_CHANNELS     = 4;
    localparam int DEF_FEATURES     = 3;
    localparam int DEF_SAMPLE_WIDTH = 10;
    localparam int DEF_TIMEOUT      = 64;

    localparam int CH_W  = $clog2(DEF_CHANNELS);
    localparam int LVL_W = $clog2(DEF_FEATURES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_EMIT = 2'd3
    } sched_state_e;

    // LSB of feature f of channel c inside the flattened feature bus.
    function automatic int feat_lsb(input int ch, input int feat,
                                    input int features, input int sample_width);
        return (ch * features + feat) * sample_width;
    endfunction

endpackage

// File: rtl/spike_channel_scheduler_if.sv
// Channel / engine / result bundle of the spike channel scheduler.
// master = scheduler side, slave = channels + engine + result consumer.
interface spike_channel_scheduler_if
    import spike_channel_scheduler_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int FEATURES     = DEF_FEATURES,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
);
    localparam int IDX_W = $clog2(CHANNELS);
    localparam int LV_W  = $clog2(FEATURES);

    logic [CHANNELS-1:0]                       ch_valid;
    logic [CHANNELS-1:0]                       ch_ready;
    logic [CHANNELS*FEATURES*SAMPLE_WIDTH-1:0] ch_features;

    logic                    eng_start;
    logic [SAMPLE_WIDTH-1:0] eng_feature;
    logic                    eng_feature_valid;
    logic                    eng_done;
    logic [LV_W-1:0]         eng_level;
    logic [LV_W-1:0]         eng_path;

    logic             res_valid;
    logic             res_ready;
    logic [IDX_W-1:0] res_channel;
    logic [LV_W-1:0]  res_level;
    logic [LV_W-1:0]  res_path;
    logic             res_error;
    logic             busy;

    modport master (
        input  ch_valid, ch_features, eng_done, eng_level, eng_path, res_ready,
        output ch_ready, eng_start, eng_feature, eng_feature_valid,
               res_valid, res_channel, res_level, res_path, res_error, busy
    );

    modport slave (
        output ch_valid, ch_features, eng_done, eng_level, eng_path, res_ready,
        input  ch_ready, eng_start, eng_feature, eng_feature_valid,
               res_valid, res_channel, res_level, res_path, res_error, busy
    );

endinterface

// File: rtl/spike_channel_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module spike_rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] grant_idx_o,
    output logic         any_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[W'(idx)]) begin
                any_o            = 1'b1;
                grant_idx_o      = W'(idx);
                grant_o[W'(idx)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_channel_scheduler.sv
// Round-robin scheduler sharing one tree-classification engine between channels.
// Optional engine watchdog: define SPIKE_SCHED_TIMEOUT_EN to enable it.
module spike_channel_scheduler
    import spike_channel_scheduler_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int FEATURES     = DEF_FEATURES,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input logic                        clk,
    input logic                        reset,
    spike_channel_scheduler_if.master  bus
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam int LV_W  = $clog2(FEATURES);
    localparam int K_W   = $clog2(FEATURES);
    localparam int WD_W  = $clog2(TIMEOUT);

    if (CHANNELS < 2 || FEATURES < 2 || TIMEOUT < 2) begin : g_param_check
        $error("spike_channel_scheduler: CHANNELS, FEATURES and TIMEOUT must be >= 2");
    end

    sched_state_e            state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [K_W-1:0]          k_q;
    logic [SAMPLE_WIDTH-1:0] buf_q [FEATURES];
    logic                    eng_start_q;
    logic [SAMPLE_WIDTH-1:0] eng_feature_q;
    logic                    eng_feature_valid_q;
    logic                    res_valid_q;
    logic [IDX_W-1:0]        res_channel_q;
    logic [LV_W-1:0]         res_level_q;
    logic [LV_W-1:0]         res_path_q;
`ifdef SPIKE_SCHED_TIMEOUT_EN
    logic [WD_W-1:0]         wd_q;
    logic                    res_error_q;
`endif

    logic [CHANNELS-1:0]     grant_onehot;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic [IDX_W-1:0]        next_ptr_d;
    logic [SAMPLE_WIDTH-1:0] grant_feat [FEATURES];

    spike_rr_arbiter #(.N(CHANNELS), .W(IDX_W)) u_arb (
        .req_i       (bus.ch_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_onehot),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    for (genvar gi = 0; gi < FEATURES; gi++) begin : g_feat_mux
        assign grant_feat[gi] =
            bus.ch_features[feat_lsb(int'(grant_idx), gi, FEATURES, SAMPLE_WIDTH) +: SAMPLE_WIDTH];
    end

    assign next_ptr_d = (grant_idx == IDX_W'(CHANNELS - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            rr_ptr_q            <= '0;
            k_q                 <= '0;
            eng_start_q         <= 1'b0;
            eng_feature_q       <= '0;
            eng_feature_valid_q <= 1'b0;
            res_valid_q         <= 1'b0;
            res_channel_q       <= '0;
            res_level_q         <= '0;
            res_path_q          <= '0;
`ifdef SPIKE_SCHED_TIMEOUT_EN
            wd_q                <= '0;
            res_error_q         <= 1'b0;
`endif
        end else begin
            eng_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        res_channel_q       <= grant_idx;
                        rr_ptr_q            <= next_ptr_d;
                        for (int i = 0; i < FEATURES; i++) buf_q[i] <= grant_feat[i];
                        eng_start_q         <= 1'b1;
                        eng_feature_q       <= grant_feat[0];
                        eng_feature_valid_q <= 1'b1;
                        k_q                 <= '0;
                        state_q             <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // buf_q shifts down so buf_q[1] is always the next feature to send
                    for (int i = 0; i < FEATURES - 1; i++) buf_q[i] <= buf_q[i+1];
                    if (k_q == K_W'(FEATURES - 1)) begin
                        eng_feature_valid_q <= 1'b0;
                        eng_feature_q       <= '0;
                        state_q             <= ST_WAIT;
`ifdef SPIKE_SCHED_TIMEOUT_EN
                        wd_q                <= '0;
`endif
                    end else begin
                        k_q           <= k_q + K_W'(1);
                        eng_feature_q <= buf_q[1];
                    end
                end
                ST_WAIT: begin
                    if (bus.eng_done) begin
                        res_level_q <= bus.eng_level;
                        res_path_q  <= bus.eng_path;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
`ifdef SPIKE_SCHED_TIMEOUT_EN
                        res_error_q <= 1'b0;
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        res_level_q <= '0;
                        res_path_q  <= '0;
                        res_error_q <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
`endif
                    end
                end
                ST_EMIT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Gated by reset so no accept is advertised on a cycle that cannot take it.
    assign bus.ch_ready          = (state_q == ST_IDLE && !reset) ? grant_onehot : '0;
    assign bus.busy              = (state_q != ST_IDLE);
    assign bus.eng_start         = eng_start_q;
    assign bus.eng_feature       = eng_feature_q;
    assign bus.eng_feature_valid = eng_feature_valid_q;
    assign bus.res_valid         = res_valid_q;
    assign bus.res_channel       = res_channel_q;
    assign bus.res_level         = res_level_q;
    assign bus.res_path          = res_path_q;
`ifdef SPIKE_SCHED_TIMEOUT_EN
    assign bus.res_error         = res_error_q;
`else
    assign bus.res_error         = 1'b0;
`endif

endmodule

// File: tb/tb_spike_channel_scheduler.sv
// Bench for spike_channel_scheduler: per-cycle job-level model plus directed scenarios.
// Timeout scenario is built only when SPIKE_SCHED_TIMEOUT_EN is defined.
module tb_spike_channel_scheduler;

    localparam int C  = 4;
    localparam int F  = 3;
    localparam int SW = 10;
    localparam int TO = 8;

    typedef struct { int ch; int lvl; int path; int err; } res_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    int eng_lat = -1;
    int eng_lvl_cfg = 0;
    int eng_path_cfg = 0;

    int   grant_log[$];
    int   grant_cyc[$];
    int   feat_log[$];
    int   start_feat_log[$];
    res_t res_log[$];
    int   res_cyc[$];

    // job-level model state
    int   m_ptr = 0;
    bit   m_active = 0;
    bit   m_res = 0;
    bit   m_fresh = 1;
    int   m_t = 0;
    int   m_ch = 0;
    int   m_lvl = 0;
    int   m_path = 0;
    int   m_err = 0;
    int   m_f[F];

    spike_channel_scheduler_if #(.CHANNELS(C), .FEATURES(F), .SAMPLE_WIDTH(SW)) sif ();

    spike_channel_scheduler #(.CHANNELS(C), .FEATURES(F), .SAMPLE_WIDTH(SW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int rr_pick(input logic [C-1:0] v, input int ptr);
        for (int i = 0; i < C; i++)
            if (v[(ptr + i) % C]) return (ptr + i) % C;
        return -1;
    endfunction

    // Engine stand-in: answers eng_lat cycles after the last serial feature.
    initial begin : engine
        sif.eng_done  = 1'b0;
        sif.eng_level = '0;
        sif.eng_path  = '0;
        forever begin
            @(negedge clk);
            if (!reset && sif.eng_start && eng_lat > 0) begin
                @(posedge clk);
                repeat (F - 2 + eng_lat) @(posedge clk);
                #1;
                sif.eng_done  = 1'b1;
                sif.eng_level = 2'(eng_lvl_cfg);
                sif.eng_path  = 2'(eng_path_cfg);
                @(posedge clk);
                #1;
                sif.eng_done = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, event logging, then model advance.
    initial begin : compare
        int pk;
        logic [C-1:0] er;
        bit efv;
        bit prev_rv;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            pk = rr_pick(sif.ch_valid, m_ptr);
            if (!reset) begin
                er = '0;
                if (!m_active && pk >= 0) er[pk] = 1'b1;
                efv = m_active && !m_res && m_t >= 1 && m_t <= F;
                chk("ch_ready", int'(sif.ch_ready), int'(er));
                chk("busy", int'(sif.busy), int'(m_active));
                chk("eng_start", int'(sif.eng_start), int'(m_active && !m_res && m_t == 1));
                chk("eng_feature_valid", int'(sif.eng_feature_valid), int'(efv));
                if (efv) chk("eng_feature", int'(sif.eng_feature), m_f[m_t-1]);
                chk("res_valid", int'(sif.res_valid), int'(m_res));
                if (m_res || m_fresh) begin
                    chk("res_channel", int'(sif.res_channel), m_res ? m_ch : 0);
                    chk("res_level", int'(sif.res_level), m_res ? m_lvl : 0);
                    chk("res_path", int'(sif.res_path), m_res ? m_path : 0);
                    chk("res_error", int'(sif.res_error), m_res ? m_err : 0);
                end
                if (m_fresh && !m_active) chk("eng_feature_rst", int'(sif.eng_feature), 0);

                if (sif.ch_ready != '0) begin
                    for (int i = 0; i < C; i++)
                        if (sif.ch_ready[i]) begin
                            grant_log.push_back(i);
                            grant_cyc.push_back(cyc);
                            break;
                        end
                end
                if (sif.eng_start) start_feat_log.push_back(int'(sif.eng_feature));
                if (sif.eng_feature_valid) feat_log.push_back(int'(sif.eng_feature));
                if (sif.res_valid && !prev_rv) begin
                    res_log.push_back('{int'(sif.res_channel), int'(sif.res_level),
                                        int'(sif.res_path), int'(sif.res_error)});
                    res_cyc.push_back(cyc);
                end
                prev_rv = sif.res_valid;
            end else begin
                prev_rv = 1'b0;
            end

            if (reset) begin
                m_active = 0; m_res = 0; m_fresh = 1; m_ptr = 0;
                m_ch = 0; m_lvl = 0; m_path = 0; m_err = 0; m_t = 0;
            end else if (!m_active) begin
                if (pk >= 0) begin
                    m_active = 1; m_fresh = 0; m_t = 1; m_ch = pk;
                    m_ptr = (pk + 1) % C;
                    for (int f = 0; f < F; f++) m_f[f] = int'(sif.ch_features[(pk*F + f)*SW +: SW]);
                end
            end else if (m_res) begin
                if (sif.res_ready) begin m_active = 0; m_res = 0; end
            end else if (m_t <= F) begin
                m_t++;
            end else if (sif.eng_done) begin
                m_res = 1; m_err = 0;
                m_lvl = int'(sif.eng_level); m_path = int'(sif.eng_path);
`ifdef SPIKE_SCHED_TIMEOUT_EN
            end else if (m_t - F == TO) begin
                m_res = 1; m_err = 1; m_lvl = 0; m_path = 0;
`endif
            end else begin
                m_t++;
            end
        end
    end

    task automatic set_feat(input int c, input int f0, input int f1, input int f2);
        sif.ch_features[(c*F + 0)*SW +: SW] = SW'(f0);
        sif.ch_features[(c*F + 1)*SW +: SW] = SW'(f1);
        sif.ch_features[(c*F + 2)*SW +: SW] = SW'(f2);
    endtask

    task automatic clear_logs();
        grant_log.delete(); grant_cyc.delete(); feat_log.delete();
        start_feat_log.delete(); res_log.delete(); res_cyc.delete();
    endtask

    // Raise the requests in mask and wait for n accepts; returns just after the last accept edge.
    task automatic serve(input logic [C-1:0] mask, input bit hold, input int n);
        logic [C-1:0] g;
        int got;
        got = 0;
        sif.ch_valid = sif.ch_valid | mask;
        for (int i = 0; i < 300 && got < n; i++) begin
            g = '0;
            @(negedge clk);
            if (!reset) g = sif.ch_ready;
            @(posedge clk);
            #1;
            if (g != '0) begin
                got++;
                if (!hold) sif.ch_valid = sif.ch_valid & ~g;
            end
        end
        chk("grants_seen", got, n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!sif.busy) break;
        end
        chk("idle_reached", int'(sif.busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grants(input string name, input int exp[$]);
        chk({name, "_count"}, grant_log.size(), exp.size());
        if (grant_log.size() == exp.size())
            foreach (exp[i]) chk(name, grant_log[i], exp[i]);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1);
    end

    initial begin : main
        reset = 1'b1;
        sif.ch_valid = '0;
        sif.res_ready = 1'b1;
        sif.ch_features = '0;
        set_feat(0, 5, 9, 3);
        set_feat(1, 100, 200, 300);
        set_feat(2, 1023, 0, 512);
        set_feat(3, 7, 77, 777);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_res_valid", int'(sif.res_valid), 0);
        chk("rst_eng_fv", int'(sif.eng_feature_valid), 0);
        @(posedge clk);
        #1;

        // round-robin with all channels held high
        eng_lat = 2; eng_lvl_cfg = 0; eng_path_cfg = 1;
        clear_logs();
        serve(4'b1111, 1'b1, 5);
        sif.ch_valid = '0;
        wait_idle();
        chk_grants("rr_order", '{0, 1, 2, 3, 0});

        // single request: features 5,9,3, engine level 1 path 2 four cycles after last feature
        eng_lat = 4; eng_lvl_cfg = 1; eng_path_cfg = 2;
        clear_logs();
        serve(4'b0001, 1'b0, 1);
        wait_idle();
        chk_grants("single_grant", '{0});
        chk("single_feat_count", feat_log.size(), 3);
        if (feat_log.size() == 3) begin
            chk("single_feat0", feat_log[0], 5);
            chk("single_feat1", feat_log[1], 9);
            chk("single_feat2", feat_log[2], 3);
        end
        chk("single_start_count", start_feat_log.size(), 1);
        if (start_feat_log.size() == 1) chk("single_start_feat", start_feat_log[0], 5);
        chk("single_res_count", res_log.size(), 1);
        if (res_log.size() == 1 && grant_cyc.size() == 1) begin
            chk("single_res_ch", res_log[0].ch, 0);
            chk("single_res_lvl", res_log[0].lvl, 1);
            chk("single_res_path", res_log[0].path, 2);
            chk("single_res_err", res_log[0].err, 0);
            chk("single_latency", res_cyc[0] - grant_cyc[0], 8);
        end

        // pointer wrap: serve 3, then 1001 -> 0 then 3
        eng_lat = 1; eng_lvl_cfg = 2; eng_path_cfg = 3;
        serve(4'b1000, 1'b0, 1);
        wait_idle();
        clear_logs();
        serve(4'b1001, 1'b0, 2);
        wait_idle();
        chk_grants("wrap_order", '{0, 3});

        // backpressure while channel 1 waits
        eng_lat = 2; eng_lvl_cfg = 2; eng_path_cfg = 1;
        clear_logs();
        sif.res_ready = 1'b0;
        serve(4'b0001, 1'b0, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sif.res_valid) break;
        end
        chk("bp_res_valid_seen", int'(sif.res_valid), 1);
        @(posedge clk);
        #1;
        sif.ch_valid = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_res_valid", int'(sif.res_valid), 1);
            chk("bp_res_ch", int'(sif.res_channel), 0);
            chk("bp_res_lvl", int'(sif.res_level), 2);
            chk("bp_res_path", int'(sif.res_path), 1);
            chk("bp_ch_ready", int'(sif.ch_ready), 0);
        end
        @(posedge clk);
        #1;
        sif.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_cycle_no_grant", int'(sif.ch_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_grant_next_cycle", int'(sif.ch_ready), 2);
        @(posedge clk);
        #1;
        sif.ch_valid = '0;
        wait_idle();
        chk_grants("bp_order", '{0, 1});

        // reset on the second feature cycle
        eng_lat = -1;
        serve(4'b0100, 1'b0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rl_busy", int'(sif.busy), 0);
        chk("rl_eng_start", int'(sif.eng_start), 0);
        chk("rl_eng_fv", int'(sif.eng_feature_valid), 0);
        chk("rl_eng_feature", int'(sif.eng_feature), 0);
        chk("rl_res_valid", int'(sif.res_valid), 0);
        chk("rl_res_channel", int'(sif.res_channel), 0);
        @(posedge clk);
        #1;
        eng_lat = 3; eng_lvl_cfg = 1; eng_path_cfg = 1;
        clear_logs();
        serve(4'b1001, 1'b0, 2);
        wait_idle();
        chk_grants("rl_order", '{0, 3});

`ifdef SPIKE_SCHED_TIMEOUT_EN
        // engine never answers: watchdog result after 8 WAIT cycles
        eng_lat = -1;
        clear_logs();
        serve(4'b0100, 1'b0, 1);
        wait_idle();
        chk("to_res_count", res_log.size(), 1);
        if (res_log.size() == 1 && grant_cyc.size() == 1) begin
            chk("to_res_ch", res_log[0].ch, 2);
            chk("to_res_err", res_log[0].err, 1);
            chk("to_res_lvl", res_log[0].lvl, 0);
            chk("to_res_path", res_log[0].path, 0);
            chk("to_latency", res_cyc[0] - grant_cyc[0], 12);
        end
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spike_channel_scheduler.md
# spike_channel_scheduler

Round-robin scheduler that shares one decision-tree classification engine among several spike-detection channels. Each channel presents a captured feature vector with a valid/ready handshake. The scheduler grants one channel, streams its features serially into the engine, and waits for the engine's leaf result. It then emits that result tagged with the channel number. It sits between the per-channel feature extractors and the single tree-traversal/MAC engine.

## Interface
- CHANNELS, 4, number of requesting channels (≥2)
- FEATURES, 3, features per vector; equals the engine's FEATURES
- SAMPLE_WIDTH, 10, bits per feature
- TIMEOUT, 64, engine-response watchdog limit in cycles (used only with the macro)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ch_valid  in  CHANNELS  per-channel request; held until accepted
- ch_ready  out  CHANNELS  one-hot accept; combinational, only in IDLE
- ch_features  in  CHANNELS*FEATURES*SAMPLE_WIDTH  channel c, feature f at bits [(c*FEATURES+f)*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- eng_start  out  1  one-cycle pulse, coincident with feature 0
- eng_feature  out  SAMPLE_WIDTH  serial feature value
- eng_feature_valid  out  1  eng_feature is valid this cycle
- eng_done  in  1  engine result strobe (engine out_valid)
- eng_level  in  $clog2(FEATURES)  leaf depth from engine
- eng_path  in  $clog2(FEATURES)  branch-direction bits from engine
- res_valid  out  1  result available; held until res_ready
- res_ready  in  1  downstream accept
- res_channel  out  $clog2(CHANNELS)  channel that produced the result
- res_level  out  $clog2(FEATURES)  registered eng_level
- res_path  out  $clog2(FEATURES)  registered eng_path
- res_error  out  1  result produced by watchdog timeout
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE → LOAD → WAIT → EMIT → IDLE.
- IDLE
  - Search ch_valid starting at rr_ptr, ascending, wrapping modulo CHANNELS; the first set bit is the grant g.
  - Drive ch_ready[g]=1 combinationally. At the clock edge, capture g and that channel's features into the buffer.
  - Set rr_ptr ← (g+1) mod CHANNELS and go to LOAD.
  - No ch_valid set: stay in IDLE, ch_ready=0.
- LOAD
  - Runs FEATURES cycles. Cycle k drives eng_feature=buffer[k] and eng_feature_valid=1; eng_start=1 on k=0 only.
  - After k=FEATURES-1, go to WAIT.
- WAIT
  - On eng_done=1, register eng_level and eng_path, set res_error=0, go to EMIT.
  - eng_done in any other state is ignored.
- EMIT
  - res_valid=1; res_channel, res_level, res_path and res_error stay stable.
  - On res_valid&res_ready, go to IDLE.
- Arbitration is fair. A channel whose valid is continuously high is served within CHANNELS grants.
- Reset
  - Takes effect at any state, including mid-LOAD and mid-WAIT.
  - All outputs go to 0, state to IDLE, rr_ptr to 0, watchdog to 0. Buffer contents are don't-care.
  - The engine has its own reset; the scheduler does not abort a running engine in any other way.

## Timing
- Grant edge to eng_start: 1 cycle. eng_start occurs in the first LOAD cycle.
- eng_feature_valid is high for exactly FEATURES consecutive cycles per job.
- eng_done edge to res_valid=1: 1 cycle.
- Minimum request-to-result: 1 + FEATURES + engine latency + 1 cycles.
- Handshake at EMIT exit:
  - If res_ready is high in the first EMIT cycle, the FSM is in IDLE on the next cycle.
  - A new grant can be issued in that same IDLE cycle.
- Only one job is in flight at a time; there is no pipelining across jobs.
- res_* outputs are don't-care while res_valid=0, but they are 0 after reset.

## Configuration
- SPIKE_SCHED_TIMEOUT_EN defined:
  - A counter increments each WAIT cycle and clears on WAIT entry.
  - If it reaches TIMEOUT-1 without eng_done, the FSM goes to EMIT with res_error=1, res_level=0, res_path=0.
  - eng_done arriving in the same cycle as expiry wins: the result is normal, with res_error=0.
- Not defined: no counter; WAIT persists until eng_done; res_error is tied to 0.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOAD, WAIT, EMIT);
  - width constants CH_W=$clog2(CHANNELS) and LVL_W=$clog2(FEATURES);
  - the feature-slice index function.
- One sub-module: spike_rr_arbiter. It is combinational: (req, ptr) → one-hot grant, grant index, any.
- The FSM, buffer, rr_ptr and watchdog stay in the top module.

## Test plan
- Single request:
  - Stimulus: ch_valid=0001, features {5,9,3}; engine returns level=1, path=2 four cycles after its last feature.
  - Response: eng_feature 5,9,3 on consecutive cycles with eng_start on 5; res_valid with channel 0, level 1, path 2, error 0.
- Round-robin:
  - Stimulus: ch_valid=1111 held.
  - Response: service order 0,1,2,3,0; each ch_ready is a single-cycle one-hot pulse.
- Pointer wrap:
  - Stimulus: after serving channel 3, ch_valid=1001.
  - Response: channel 0 is granted next, then channel 3.
- Backpressure:
  - Stimulus: res_ready=0 for 10 cycles during EMIT while ch_valid=0010.
  - Response: res_* stable and ch_ready=0 throughout; channel 1 is granted in the cycle after res_ready rises.
- Timeout (macro on, TIMEOUT=8):
  - Stimulus: engine never asserts eng_done.
  - Response: res_valid with res_error=1, level 0, path 0, exactly 8 WAIT cycles after the last feature.
- Reset mid-LOAD:
  - Stimulus: reset asserted on the second feature cycle.
  - Response: next cycle all outputs are 0, busy=0, and the next grant starts from channel 0.
